max_unpool2x2: RTL and testbench
================================

Name: max_unpool2x2

Overview:
- Streaming 2x2 max-unpooling block, the inverse of the 2x2 maxpool stage.
- Accepts one row of pooled values with 2-bit argmax indices.
- Reconstructs the two full-resolution output rows in raster order. The selected position carries the pooled value; the other three positions of each 2x2 window are zero.
- Sits in the decoder / upsampling path, fed by the pooling stage's value+index stream, driving the next conv line buffer.

Parameters:
- DATA_WIDTH, 32, signed sample width.
- OUT_W, 8, output row width in pixels. Must be even and >=2. IN_COLS = OUT_W/2 pooled values per row.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pooled sample valid.
- in_ready  output  1  block accepts pooled sample.
- in_data  input  DATA_WIDTH  signed pooled value.
- in_idx  input  2  argmax position: 0=top-left(a), 1=top-right(b), 2=bottom-left(c), 3=bottom-right(d).
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts pixel.
- out_data  output  DATA_WIDTH  signed reconstructed pixel.
- out_eol  output  1  high with the last pixel of each output row.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_eol=0.
  - state=TOP, phase=0, col=0, buffer contents don't-care.
  - in_ready forced 0 while rst_n=0.
  - Reset mid-row discards the partial row; the next accepted input is column 0 of a new top row.
- Output register: out_data/out_valid/out_eol are registered. A slot is free when (!out_valid || out_ready).
- Output hold: while out_valid=1 and out_ready=0, out_data and out_eol hold stable.
- Buffer: IN_COLS entries of {in_data, in_idx}, written at index col on acceptance.
- State TOP, phase 0:
  - in_ready = slot free.
  - On in_valid&&in_ready: store to buffer[col]; out_data <= (in_idx==0) ? in_data : 0; out_valid<=1; out_eol<=0; phase<=1.
- State TOP, phase 1:
  - in_ready=0.
  - When slot free: out_data <= (buf[col].idx==1) ? buf[col].data : 0; phase<=0.
  - If col==IN_COLS-1: out_eol<=1, col<=0, state<=BOT. Else col<=col+1.
- State BOT:
  - in_ready=0.
  - Each free slot emits one pixel: even pixel <= (idx==2 ? data : 0), odd pixel <= (idx==3 ? data : 0), stepping col after each odd pixel.
  - Last odd pixel (col==IN_COLS-1): out_eol<=1, col<=0, state<=TOP.
- If no new output is loaded while the slot is free: out_valid<=0 and out_eol<=0.
- Latency: first output pixel valid the cycle after input acceptance.
- Throughput with out_ready=1:
  - TOP row: 1 input per 2 cycles, 1 pixel per cycle.
  - BOT row: OUT_W cycles with no input accepted.
- Values pass unmodified (signed, no width change); zero fill is all-zero bits.
- in_valid without in_ready is held by upstream; the block never drops or duplicates inputs.
- A new top row may be accepted the cycle the final BOT pixel is taken (no bubble beyond the register handshake).

Test Plan:
- OUT_W=4, out_ready=1; inputs (5,idx0),(7,idx3) -> row0: 5,0,0,0 with eol on 4th; row1: 0,0,0,7 with eol on 4th.
- OUT_W=4; inputs (-3,idx1),(9,idx2) -> row0: 0,-3,0,0; row1: 0,0,9,0. Confirms sign preserved (0xFFFFFFFD).
- Backpressure: drop out_ready for 3 cycles mid-row -> out_data/out_eol stable, in_ready=0, no pixel lost; sequence identical to the unstalled case.
- Two consecutive pooled rows with in_valid held high -> in_ready=0 throughout BOT; exactly 2*OUT_W pixels per pooled row; second row's outputs correct.
- Reset asserted during BOT after 1 pixel -> outputs 0 immediately; after release, inputs (1,idx3),(2,idx0) produce row0: 0,0,2,0 and row1: 0,1,0,0.
- OUT_W=2 boundary; input (4,idx2) -> row0: 0,0 eol; row1: 4,0 eol.

Source files
------------

// File: rtl/max_unpool2x2.sv
// Streaming 2x2 max-unpooling: one pooled row of {value, argmax} in, two
// full-resolution raster rows out, non-selected window positions zero-filled.
module max_unpool2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_W      = 8     // even, >= 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_eol
);
    localparam int IN_COLS = OUT_W / 2;
    localparam int COL_W   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int DEPTH   = 1 << COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_COLS - 1);

    typedef enum logic {TOP, BOT} state_t;

    state_t                  state, state_nxt;
    logic                    phase, phase_nxt;
    logic [COL_W-1:0]        col, col_nxt;
    logic                    slot_free;
    logic                    load;
    logic                    eol_nxt;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   pix_nxt;

    // Row buffer: the bottom row is rebuilt from the same pooled samples.
    logic [DATA_WIDTH-1:0]   line_data [DEPTH];
    logic [1:0]              line_idx  [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [1:0]              rd_idx;

    assign slot_free = !out_valid || out_ready;
    assign rd_data   = line_data[col];
    assign rd_idx    = line_idx[col];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_data[col] <= in_data;
            line_idx[col]  <= in_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TOP;
            phase     <= 1'b0;
            col       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            col   <= col_nxt;
            if (slot_free) begin
                out_valid <= load;
                out_eol   <= load && eol_nxt;
                if (load) out_data <= pix_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        col_nxt   = col;
        in_ready  = 1'b0;
        load      = 1'b0;
        wr_en     = 1'b0;
        eol_nxt   = 1'b0;
        pix_nxt   = '0;
        case (state)
            TOP: begin
                if (!phase) begin
                    in_ready = rst_n && slot_free;
                    if (in_valid && in_ready) begin
                        wr_en     = 1'b1;
                        load      = 1'b1;
                        pix_nxt   = (in_idx == 2'd0) ? in_data : '0;
                        phase_nxt = 1'b1;
                    end
                end else if (slot_free) begin
                    load      = 1'b1;
                    pix_nxt   = (rd_idx == 2'd1) ? rd_data : '0;
                    phase_nxt = 1'b0;
                    if (col == LAST_COL) begin
                        eol_nxt   = 1'b1;
                        col_nxt   = '0;
                        state_nxt = BOT;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            BOT: begin
                // phase doubles as the even/odd pixel selector within a window
                if (slot_free) begin
                    load = 1'b1;
                    if (!phase) begin
                        pix_nxt   = (rd_idx == 2'd2) ? rd_data : '0;
                        phase_nxt = 1'b1;
                    end else begin
                        pix_nxt   = (rd_idx == 2'd3) ? rd_data : '0;
                        phase_nxt = 1'b0;
                        if (col == LAST_COL) begin
                            eol_nxt   = 1'b1;
                            col_nxt   = '0;
                            state_nxt = TOP;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = TOP;
        endcase
    end
endmodule

// File: tb/tb_max_unpool2x2.sv
// Bench for max_unpool2x2: per-cycle queue model plus literal row checks,
// main instance OUT_W=4, second instance OUT_W=2 for the narrow boundary.
module tb_max_unpool2x2;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int IC = W / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready, out_eol;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    in_idx;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_eol;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_in_idx;

    max_unpool2x2 #(.DATA_WIDTH(DW), .OUT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol)
    );

    max_unpool2x2 #(.DATA_WIDTH(DW), .OUT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_idx(b_in_idx),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_eol(b_out_eol)
    );

    typedef struct { int d; bit e; } pix_t;

    pix_t exp_q[$];
    pix_t obs[$];
    pix_t obs2[$];
    int   row_d[$];
    int   row_i[$];
    int   ed[$];
    bit   ee[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   stall_n = 0;
    int   wn;
    bit   bp_rand = 0;
    bit   bp_force = 0;
    bit   prev_stall = 0;
    int   prev_d;
    bit   prev_e;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Spec-level model: each pooled sample yields its two top-row pixels at once;
    // a completed pooled row yields the whole bottom row.
    task automatic model_accept(input int d, input int i);
        row_d.push_back(d);
        row_i.push_back(i);
        exp_q.push_back(pix_t'{(i == 0) ? d : 0, 1'b0});
        exp_q.push_back(pix_t'{(i == 1) ? d : 0, row_d.size() == IC});
        if (row_d.size() == IC) begin
            for (int c = 0; c < IC; c++) begin
                exp_q.push_back(pix_t'{(row_i[c] == 2) ? row_d[c] : 0, 1'b0});
                exp_q.push_back(pix_t'{(row_i[c] == 3) ? row_d[c] : 0, c == IC - 1});
            end
            row_d.delete();
            row_i.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = bp_force ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Single compare process, mid-cycle, against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            row_d.delete();
            row_i.delete();
            prev_stall = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_in_ready", in_ready, 0);
        end else begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", $signed(out_data), exp_q[0].d);
                chk("out_eol", out_eol, exp_q[0].e);
            end
            chk("in_ready", in_ready, (exp_q.size() <= 1) && (!out_valid || out_ready));
            if (prev_stall) begin
                chk("hold_data", $signed(out_data), prev_d);
                chk("hold_eol", out_eol, prev_e);
            end
            prev_stall = out_valid && !out_ready;
            prev_d = $signed(out_data);
            prev_e = out_eol;
            if (prev_stall) stall_n++;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                obs.push_back(pix_t'{$signed(out_data), out_eol});
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) model_accept($signed(in_data), int'(in_idx));
            if (b_out_valid) obs2.push_back(pix_t'{$signed(b_out_data), b_out_eol});
        end
    end

    task automatic send(input int d, input int i);
        int n = 0;
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = i[1:0];
        while (!got && n < 300) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_obs(input string name);
        chk({name, "_len"}, obs.size(), ed.size());
        for (int k = 0; k < ed.size() && k < obs.size(); k++) begin
            chk($sformatf("%s_d%0d", name, k), obs[k].d, ed[k]);
            chk($sformatf("%s_e%0d", name, k), obs[k].e, ee[k]);
        end
    endtask

    initial begin
        in_valid = 0; in_data = 0; in_idx = 0; out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_idx = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_eol", out_eol, 0);
        chk("init_in_ready", in_ready, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        obs.delete();
        send(5, 0); send(7, 3); drain();
        ed = '{5, 0, 0, 0, 0, 0, 0, 7};
        ee = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_obs("basic");

        obs.delete();
        send(-3, 1); send(9, 2); drain();
        ed = '{0, -3, 0, 0, 0, 0, 9, 0};
        check_obs("signed");
        if (obs.size() > 1) chk("signed_bits", {32'b0, obs[1].d}, 64'hFFFF_FFFD);

        obs.delete();
        stall_n = 0;
        fork
            begin send(5, 0); send(7, 3); end
            begin
                wn = 0;
                while (obs.size() < 2 && wn < 100) begin @(posedge clk); wn++; end
                bp_force = 1;
                repeat (3) @(posedge clk);
                bp_force = 0;
            end
        join
        drain();
        ed = '{5, 0, 0, 0, 0, 0, 0, 7};
        check_obs("stall");
        chk("stall_cycles", stall_n >= 3, 1);

        obs.delete();
        send(11, 0); send(12, 1); send(13, 2); send(14, 3); drain();
        ed = '{11, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 14};
        ee = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        check_obs("two_rows");

        obs.delete();
        send(21, 1); send(22, 2);
        wn = 0;
        while (obs.size() < 5 && wn < 100) begin @(posedge clk); wn++; end
        chk("bot_reached", obs.size(), 5);
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_eol", out_eol, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        obs.delete();
        send(1, 3); send(2, 0); drain();
        ed = '{0, 0, 2, 0, 0, 1, 0, 0};
        ee = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_obs("after_rst");

        obs2.delete();
        b_in_valid = 1; b_in_data = 4; b_in_idx = 2'd2;
        @(negedge clk);
        chk("w2_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1 b_in_valid = 0;
        repeat (8) @(posedge clk);
        chk("w2_len", obs2.size(), 4);
        if (obs2.size() == 4) begin
            chk("w2_d0", obs2[0].d, 0); chk("w2_e0", obs2[0].e, 0);
            chk("w2_d1", obs2[1].d, 0); chk("w2_e1", obs2[1].e, 1);
            chk("w2_d2", obs2[2].d, 4); chk("w2_e2", obs2[2].e, 0);
            chk("w2_d3", obs2[3].d, 0); chk("w2_e3", obs2[3].e, 1);
        end

        obs.delete();
        bp_rand = 1;
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(int'($urandom), int'($urandom_range(0, 3)));
        end
        drain();
        bp_rand = 0;
        chk("rand_count", obs.size(), 24 * 4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
